// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, byte timing constants and a pointer helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        LOCKED    = 2'd3
    } arb_state_e;

    localparam int CLKS_PER_BIT = 868;
    localparam int BYTE_CYCLES  = 10 * CLKS_PER_BIT;

    // Roughly two byte times at 115200 baud from a 100 MHz clock.
    localparam int DEF_TIMEOUT_CYCLES = 16384;

    // Requester index that follows v, wrapping at n.
    function automatic int next_ptr(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping. Ports: req_i, ptr_i in; onehot_o, idx_o, found_o out.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        int            j;
        logic [PW-1:0] jj;
        j        = 0;
        jj       = '0;
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = PW'(j);
            if (!found_o && req_i[jj]) begin
                found_o      = 1'b1;
                idx_o        = jj;
                onehot_o[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ
// byte producers, one byte in flight, with a done watchdog.
// Ports: clk_in, rst_in (async, active-high), req_in/data_in/ack_out
// per requester, grant_out, busy_out, err_out, uart_datav_out,
// uart_byte_out to the transmitter, uart_active_in/uart_done_in from it.
// Build option UART_ARB_LOCK_EN adds last_in and holds the grant for
// a whole packet until a byte flagged last completes.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_REQ-1:0]   req_in,
    input  logic [NUM_REQ*8-1:0] data_in,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   last_in,
`endif
    output logic [NUM_REQ-1:0]   ack_out,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic                 busy_out,
    output logic                 err_out,
    output logic                 uart_datav_out,
    output logic [7:0]           uart_byte_out,
    input  logic                 uart_active_in,
    input  logic                 uart_done_in
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [7:0]           byte_q, byte_d;
    logic [WW-1:0]        wdog_q, wdog_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [PW-1:0]        pick_idx;
    logic                 pick_found;
    logic [7:0]           pick_byte;
    logic [PW-1:0]        ptr_next;
    logic                 wd_expire;
    logic                 keep_lock;

`ifdef UART_ARB_LOCK_EN
    logic                 last_q, last_d;
    logic [7:0]           own_byte;
    assign own_byte  = data_in[{idx_q, 3'b000} +: 8];
    // A non-final byte completing keeps the same owner.
    assign keep_lock = uart_done_in && !last_q;
`else
    assign keep_lock = 1'b0;
`endif

    uart_tx_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req_i    (req_in),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    assign pick_byte = data_in[{pick_idx, 3'b000} +: 8];
    assign ptr_next  = PW'(next_ptr(int'(idx_q), NUM_REQ));
    assign wd_expire = (wdog_q == WD_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            byte_q  <= '0;
            wdog_q  <= '0;
`ifdef UART_ARB_LOCK_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            wdog_q  <= wdog_d;
`ifdef UART_ARB_LOCK_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        wdog_d  = wdog_q;
`ifdef UART_ARB_LOCK_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A still-active transmitter blocks a new issue.
                if (pick_found && !uart_active_in) begin
                    grant_d = pick_oh;
                    idx_d   = pick_idx;
                    byte_d  = pick_byte;
`ifdef UART_ARB_LOCK_EN
                    last_d  = last_in[pick_idx];
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                wdog_d = wdog_q + WW'(1);
                // Done has priority over a same-cycle expiry.
                if (uart_done_in || wd_expire) begin
                    if (keep_lock) begin
                        state_d = LOCKED;
                    end else begin
                        grant_d = '0;
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
`ifdef UART_ARB_LOCK_EN
                if (req_in[idx_q] && !uart_active_in) begin
                    byte_d  = own_byte;
                    last_d  = last_in[idx_q];
                    state_d = ISSUE;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_comb begin
        uart_datav_out = (state_q == ISSUE);
        ack_out        = (state_q == ISSUE) ? grant_q : '0;
        busy_out       = (state_q != IDLE);
        err_out        = (state_q == WAIT_DONE) && !uart_done_in
                         && wd_expire;
        grant_out      = grant_q;
        uart_byte_out  = byte_q;
    end

endmodule
